// File: rtl/bc_pkg.sv
// Shared FSM state type and default sizing for the bulls-and-cows scoring engine.
package bc_pkg;

  typedef enum logic [2:0] {
    NOSECRET,
    READY,
    CHECK,
    SCORE,
    RESULT,
    OVER
  } bc_state_t;

  localparam int unsigned BC_DIGITS    = 4;
  localparam int unsigned BC_DW        = 4;
  localparam int unsigned BC_MAX_TRIES = 8;

endpackage

// File: rtl/bc_dup_check.sv
// Combinational detector: flags a code in which any two digits are equal.
module bc_dup_check
  import bc_pkg::*;
#(
  parameter int unsigned DIGITS = BC_DIGITS,
  parameter int unsigned DW     = BC_DW
) (
  input  logic [DIGITS*DW-1:0] code,
  output logic                 dup
);

  always_comb begin
    dup = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      for (int unsigned j = i + 1; j < DIGITS; j++) begin
        if (code[i*DW +: DW] == code[j*DW +: DW]) dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows game engine: holds a secret, scores one guess digit per cycle, tracks tries and game outcome.
module bulls_cows_engine
  import bc_pkg::*;
#(
  parameter  int unsigned DIGITS    = BC_DIGITS,
  parameter  int unsigned DW        = BC_DW,
  parameter  int unsigned MAX_TRIES = BC_MAX_TRIES,
  localparam int unsigned CW        = $clog2(DIGITS + 1),
  localparam int unsigned TW        = $clog2(MAX_TRIES + 1),
  localparam int unsigned IW        = $clog2(DIGITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 secret_load,
  input  logic [DIGITS*DW-1:0] secret,
  input  logic                 guess_valid,
  output logic                 guess_ready,
  input  logic [DIGITS*DW-1:0] guess,
  output logic                 result_valid,
  output logic [CW-1:0]        bulls,
  output logic [CW-1:0]        cows,
  output logic                 invalid,
  output logic [TW-1:0]        tries,
  output logic                 win,
  output logic                 lose,
  output logic                 secret_err
);

  bc_state_t state, state_next;

  logic [DIGITS*DW-1:0] secret_q, guess_q;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        acc_bulls, acc_cows, bulls_sum, cows_sum;
  logic [TW-1:0]        tries_inc;
  logic [DW-1:0]        g_digit, s_digit;
  logic                 secret_dup, guess_dup;
  logic                 bull_hit, cow_hit, seen_elsewhere, last_digit;

  bc_dup_check #(.DIGITS(DIGITS), .DW(DW)) u_secret_dup (.code(secret),  .dup(secret_dup));
  bc_dup_check #(.DIGITS(DIGITS), .DW(DW)) u_guess_dup  (.code(guess_q), .dup(guess_dup));

  always_comb begin
    g_digit        = '0;
    s_digit        = '0;
    seen_elsewhere = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        g_digit = guess_q[i*DW +: DW];
        s_digit = secret_q[i*DW +: DW];
      end
    end
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (IW'(j) != idx && secret_q[j*DW +: DW] == g_digit) seen_elsewhere = 1'b1;
    end
  end

  assign bull_hit   = (g_digit == s_digit);
  assign cow_hit    = !bull_hit && seen_elsewhere;
  assign bulls_sum  = acc_bulls + CW'(bull_hit);
  assign cows_sum   = acc_cows + CW'(cow_hit);
  assign last_digit = (idx == IW'(DIGITS - 1));
  assign tries_inc  = (tries == TW'(MAX_TRIES)) ? tries : tries + 1'b1;

  assign guess_ready  = (state == READY) && !secret_load;
  assign result_valid = (state == RESULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NOSECRET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (secret_load) begin
      state_next = secret_dup ? NOSECRET : READY;
    end else begin
      case (state)
        READY:   if (guess_valid) state_next = CHECK;
        CHECK:   state_next = guess_dup ? RESULT : SCORE;
        SCORE:   if (last_digit) state_next = RESULT;
        RESULT:  state_next = (win || lose) ? OVER : READY;
        default: state_next = state;
      endcase
    end
  end

  // Scores build in private accumulators; the visible outputs and game flags
  // move only on the final SCORE edge so they are current when RESULT pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      secret_q   <= '0;
      guess_q    <= '0;
      idx        <= '0;
      acc_bulls  <= '0;
      acc_cows   <= '0;
      bulls      <= '0;
      cows       <= '0;
      invalid    <= 1'b0;
      tries      <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      secret_err <= 1'b0;
    end else if (secret_load) begin
      secret_q   <= secret;
      tries      <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      bulls      <= '0;
      cows       <= '0;
      secret_err <= secret_dup;
    end else begin
      case (state)
        READY: if (guess_valid) guess_q <= guess;
        CHECK: begin
          if (guess_dup) begin
            invalid <= 1'b1;
            bulls   <= '0;
            cows    <= '0;
          end else begin
            idx       <= '0;
            acc_bulls <= '0;
            acc_cows  <= '0;
          end
        end
        SCORE: begin
          idx       <= idx + 1'b1;
          acc_bulls <= bulls_sum;
          acc_cows  <= cows_sum;
          if (last_digit) begin
            bulls   <= bulls_sum;
            cows    <= cows_sum;
            invalid <= 1'b0;
            tries   <= tries_inc;
            if (bulls_sum == CW'(DIGITS))             win  <= 1'b1;
            else if (tries_inc == TW'(MAX_TRIES))     lose <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Self-checking bench for bulls_cows_engine: directed game scenarios plus randomized play against a game-level model.
module tb_bulls_cows_engine;

  localparam int D  = 4;
  localparam int W  = 4;
  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        secret_load = 1'b0;
  logic        guess_valid = 1'b0;
  logic [15:0] secret = '0;
  logic [15:0] guess = '0;
  logic        guess_ready, result_valid, invalid, win, lose, secret_err;
  logic [2:0]  bulls, cows;
  logic [3:0]  tries;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bulls_cows_engine #(.DIGITS(D), .DW(W), .MAX_TRIES(MT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .secret_load  (secret_load),
    .secret       (secret),
    .guess_valid  (guess_valid),
    .guess_ready  (guess_ready),
    .guess        (guess),
    .result_valid (result_valid),
    .bulls        (bulls),
    .cows         (cows),
    .invalid      (invalid),
    .tries        (tries),
    .win          (win),
    .lose         (lose),
    .secret_err   (secret_err)
  );

  // Game-level model: a guess takes a fixed number of cycles, then its score appears.
  bit          m_have, m_busy, m_rv, m_over, m_pinv, m_inv, m_win, m_lose, m_err, m_rdy;
  int          m_cnt, m_pb, m_pc, m_bulls, m_cows, m_tries;
  logic [15:0] m_secret = '0;

  function automatic bit has_dup(input logic [15:0] c);
    for (int i = 0; i < D; i++)
      for (int j = i + 1; j < D; j++)
        if (c[i*W +: W] == c[j*W +: W]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic score(input logic [15:0] s, input logic [15:0] g, output int b, output int c);
    bit found;
    b = 0;
    c = 0;
    for (int i = 0; i < D; i++) begin
      if (g[i*W +: W] == s[i*W +: W]) b++;
      else begin
        found = 1'b0;
        for (int j = 0; j < D; j++) if (s[j*W +: W] == g[i*W +: W]) found = 1'b1;
        if (found) c++;
      end
    end
  endtask

  function automatic bit m_ready();
    return m_have && !m_busy && !m_rv && !m_over;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_have = 0; m_busy = 0; m_rv = 0; m_over = 0; m_inv = 0;
      m_win = 0; m_lose = 0; m_err = 0; m_bulls = 0; m_cows = 0; m_tries = 0;
    end else begin
      m_rdy = m_ready();
      m_rv  = 0;
      if (secret_load) begin
        m_secret = secret;
        m_busy = 0; m_tries = 0; m_win = 0; m_lose = 0; m_bulls = 0; m_cows = 0;
        m_err  = has_dup(secret);
        m_have = !m_err;
        m_over = 0;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_rv   = 1;
          if (m_pinv) begin
            m_inv = 1; m_bulls = 0; m_cows = 0;
          end else begin
            m_inv = 0; m_bulls = m_pb; m_cows = m_pc;
            if (m_tries < MT) m_tries++;
            if (m_pb == D) m_win = 1;
            else if (m_tries == MT) m_lose = 1;
            if (m_win || m_lose) m_over = 1;
          end
        end
      end else if (m_rdy && guess_valid) begin
        m_busy = 1;
        if (has_dup(guess)) begin
          m_pinv = 1;
          m_cnt  = 1;
        end else begin
          m_pinv = 0;
          m_cnt  = D + 1;
          score(m_secret, guess, m_pb, m_pc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("guess_ready", int'(guess_ready), int'(m_ready() && !secret_load));
    chk("bulls", int'(bulls), m_bulls);
    chk("cows", int'(cows), m_cows);
    chk("invalid", int'(invalid), int'(m_inv));
    chk("tries", int'(tries), m_tries);
    chk("win", int'(win), int'(m_win));
    chk("lose", int'(lose), int'(m_lose));
    chk("secret_err", int'(secret_err), int'(m_err));
    chk("win_lose_excl", int'(win && lose), 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [15:0] s);
    secret_load = 1'b1;
    secret = s;
    tick();
    secret_load = 1'b0;
    #1;
  endtask

  task automatic send_guess(input logic [15:0] g);
    bit acc;
    acc = 1'b0;
    guess = g;
    guess_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      acc = guess_ready;
      tick();
    end
    guess_valid = 1'b0;
    if (!acc) chk("guess_accept_timeout", 0, 1);
  endtask

  task automatic wait_rv(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (result_valid) return;
    end
    chk("result_timeout", 0, 1);
    lat = -1;
  endtask

  task automatic count_rv(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (result_valid) pulses++;
    end
  endtask

  function automatic logic [15:0] rand_code(input bit allow_dup);
    logic [15:0] c;
    bit [7:0]    used;
    int          d;
    used = '0;
    c = '0;
    for (int i = 0; i < D; i++) begin
      d = $urandom_range(0, 7);
      if (!allow_dup) while (used[d]) d = (d + 1) % 8;
      used[d] = 1'b1;
      c[i*W +: W] = d[3:0];
    end
    return c;
  endfunction

  initial begin
    int lat, n, r;
    repeat (3) tick();
    chk("rst_tries", int'(tries), 0);
    chk("rst_ready", int'(guess_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    rst_n = 1'b1;

    guess_valid = 1'b1;
    guess = 16'h1234;
    repeat (4) begin
      tick();
      chk("nosecret_ready", int'(guess_ready), 0);
    end
    guess_valid = 1'b0;

    // exact match wins on the first try
    load(16'h1234);
    chk("load_ready", int'(guess_ready), 1);
    send_guess(16'h1234);
    wait_rv(lat);
    chk("win_latency", lat, 5);
    chk("win_bulls", int'(bulls), 4);
    chk("win_cows", int'(cows), 0);
    chk("win_tries", int'(tries), 1);
    chk("win_flag", int'(win), 1);
    chk("win_ready", int'(guess_ready), 0);
    tick();
    chk("over_ready", int'(guess_ready), 0);

    load(16'h1234);
    send_guess(16'h4321);
    wait_rv(lat);
    chk("g4321_bulls", int'(bulls), 0);
    chk("g4321_cows", int'(cows), 4);
    send_guess(16'h1243);
    wait_rv(lat);
    chk("g1243_bulls", int'(bulls), 2);
    chk("g1243_cows", int'(cows), 2);
    chk("g1243_tries", int'(tries), 2);

    send_guess(16'h1123);
    wait_rv(lat);
    chk("inv_latency", lat, 1);
    chk("inv_flag", int'(invalid), 1);
    chk("inv_bulls", int'(bulls), 0);
    chk("inv_cows", int'(cows), 0);
    chk("inv_tries", int'(tries), 2);
    load(16'h1224);
    chk("dupsecret_err", int'(secret_err), 1);
    chk("dupsecret_ready", int'(guess_ready), 0);

    load(16'h1234);
    for (int g = 0; g < MT; g++) begin
      send_guess(16'h5678);
      wait_rv(lat);
      chk("miss_bulls", int'(bulls), 0);
      chk("miss_cows", int'(cows), 0);
    end
    chk("lose_tries", int'(tries), 8);
    chk("lose_flag", int'(lose), 1);
    chk("lose_win", int'(win), 0);
    tick();
    chk("lose_ready", int'(guess_ready), 0);

    // reload while scoring aborts the guess
    load(16'h1234);
    send_guess(16'h1243);
    tick();
    tick();
    load(16'h2143);
    chk("abort_tries", int'(tries), 0);
    chk("abort_ready", int'(guess_ready), 1);
    count_rv(8, n);
    chk("abort_no_rv", n, 0);

    send_guess(16'h1243);
    wait_rv(lat);
    chk("g2143_bulls", int'(bulls), 2);
    chk("g2143_cows", int'(cows), 2);
    tick();
    send_guess(16'h2143);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_bulls", int'(bulls), 0);
    chk("midrst_cows", int'(cows), 0);
    chk("midrst_tries", int'(tries), 0);
    chk("midrst_rv", int'(result_valid), 0);
    chk("midrst_ready", int'(guess_ready), 0);
    tick();
    rst_n = 1'b1;
    count_rv(8, n);
    chk("midrst_no_rv", n, 0);
    chk("midrst_post_ready", int'(guess_ready), 0);

    // load and guess in the same cycle: the load wins
    load(16'h1234);
    secret_load = 1'b1;
    secret = 16'h5612;
    guess_valid = 1'b1;
    guess = 16'h1234;
    tick();
    secret_load = 1'b0;
    guess_valid = 1'b0;
    #1;
    chk("collide_ready", int'(guess_ready), 1);
    count_rv(6, n);
    chk("collide_no_rv", n, 0);
    send_guess(16'h5612);
    wait_rv(lat);
    chk("collide_new_secret", int'(bulls), 4);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      secret_load = (!m_have || m_over) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      if (secret_load) secret = rand_code($urandom_range(0, 3) == 0);
      guess_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 5);
      guess = (r == 0) ? m_secret : rand_code(r == 1);
      tick();
    end
    rst_n = 1'b1;
    secret_load = 1'b0;
    guess_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bulls_cows_engine.md
BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

Interface
REQ-001 Parameter DIGITS, default 4: number of digits per code; legal range 2..8.
REQ-002 Parameter DW, default 4: bits per digit; digit i is bits [i*DW +: DW].
REQ-003 Parameter MAX_TRIES, default 8: number of valid guesses allowed per game.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 secret_load  in  1  one-cycle strobe; capture secret and start a new game.
REQ-008 secret  in  DIGITS*DW  secret code.
REQ-009 guess_valid  in  1  guess offered.
REQ-010 guess_ready  out  1  engine can accept a guess; high only in READY and only while secret_load=0.
REQ-011 guess  in  DIGITS*DW  guess code.
REQ-012 result_valid  out  1  one-cycle pulse when bulls, cows and invalid are updated.
REQ-013 bulls  out  $clog2(DIGITS+1)  count of exact-position matches.
REQ-014 cows  out  $clog2(DIGITS+1)  count of digits present at a different position.
REQ-015 invalid  out  1  last guess had a repeated digit.
REQ-016 tries  out  $clog2(MAX_TRIES+1)  valid guesses scored this game.
REQ-017 win, lose, secret_err  out  1 each  sticky game-status flags.

Function
REQ-018 FSM states: NOSECRET, READY, CHECK, SCORE, RESULT, OVER.
REQ-019 secret_load SHALL act in any state: it captures secret, clears tries, win, lose, bulls and cows, and aborts any scoring in progress without a result_valid pulse.
REQ-020 If the captured secret contains a repeated digit, the FSM SHALL set secret_err=1 and go to NOSECRET; otherwise it SHALL clear secret_err and go to READY.
REQ-021 A guess is accepted on an edge where guess_valid and guess_ready are both high; the guess SHALL be registered and the FSM SHALL move to CHECK.
REQ-022 secret_load together with guess_valid in the same cycle: the load wins and the guess is not accepted.
REQ-023 CHECK (1 cycle): if the guess contains a repeated digit, the FSM SHALL go to RESULT with invalid=1, bulls=0, cows=0 and tries unchanged; otherwise it SHALL clear the accumulators and go to SCORE.
REQ-024 SCORE (exactly DIGITS cycles): index i runs 0..DIGITS-1, one digit per cycle.
  - guess digit i equal to secret digit i: bulls+1.
  - otherwise, guess digit i equal to any other secret digit: cows+1.
REQ-025 Latency from the accept edge t: a valid guess asserts result_valid after edge t+DIGITS+1; an invalid guess asserts it after edge t+1.
REQ-026 RESULT (1 cycle) SHALL assert result_valid and, for a valid guess, increment tries.
  - bulls==DIGITS: set win, go to OVER.
  - else tries (after increment) ==MAX_TRIES: set lose, go to OVER.
  - else: go to READY.
REQ-027 bulls, cows and invalid SHALL hold their values between result_valid pulses.
REQ-028 OVER: guess_ready=0; only secret_load leaves this state.
REQ-029 tries SHALL saturate at MAX_TRIES; win and lose SHALL never both be 1.

Reset
REQ-030 While rst_n=0, outputs SHALL be: state NOSECRET, guess_ready=0, result_valid=0, bulls=0, cows=0, invalid=0, tries=0, win=0, lose=0, secret_err=0.
REQ-031 Reset asserted mid-SCORE SHALL discard the guess immediately, with no result_valid after release.
REQ-032 After reset release, no guess SHALL be accepted until a legal secret_load.

Structure
REQ-033 Package bc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-034 Sub-module bc_dup_check (combinational, parameters DIGITS and DW, output dup) SHALL be instantiated twice: once on the secret, once on the registered guess.

Verification (DIGITS=4, DW=4, MAX_TRIES=8)
REQ-035 secret_load 16'h1234, then guess 16'h1234 -> after 5 edges: result_valid=1, bulls=4, cows=0, tries=1, win=1, guess_ready=0.
REQ-036 secret 16'h1234, guesses 16'h4321 then 16'h1243 -> first bulls=0, cows=4; second bulls=2, cows=2; tries=2.
REQ-037 Guess 16'h1123 -> result after 1 edge: invalid=1, bulls=0, cows=0, tries unchanged; then secret_load 16'h1224 -> secret_err=1, guess_ready=0.
REQ-038 Eight guesses of 16'h5678 against secret 16'h1234 -> each bulls=0, cows=0; after the 8th: tries=8, lose=1, guess_ready=0.
REQ-039 secret_load during SCORE -> no result_valid pulse, tries=0, READY; rst_n=0 during SCORE -> all outputs 0 immediately.
REQ-040 secret_load and guess_valid asserted in the same cycle -> guess not accepted, next cycle READY with new secret.
